regfile_32x64: RTL

- 32-entry x 64-bit architectural register file for the single-cycle/pipelined LEGv8 datapath.
- Directly downstream of the 5-to-32 write-enable decoder (decoder5_32): consumes its one-hot output to select the written register.
- Two combinational read ports, one synchronous write port.
- X31 (XZR) is hardwired to zero.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/decoder5_32.sv | 18 +
 rtl/regfile_word.sv | 27 ++
 rtl/regfile_32x64.sv | 83 ++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32-entry LEGv8 register file.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;
    localparam int ZERO_REG  = 31;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [63:0]          word_t;

endpackage : regfile_pkg

// File: rtl/decoder5_32.sv
// 5-to-32 one-hot decoder with enable; drives the register file write enables.
module decoder5_32 (
    input  logic [4:0]  addr,
    input  logic        en,
    output logic [31:0] y
);

    // One-hot decode, all-zero when disabled
    always_comb begin
        y = 32'd0;
        if (en) begin
            y[addr] = 1'b1;
        end else begin
            y = 32'd0;
        end
    end

endmodule : decoder5_32

// File: rtl/regfile_word.sv
// One register-file word: WIDTH enabled D flip-flops with synchronous clear.
module regfile_word #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // Word storage; clear has priority over a write on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= {WIDTH{1'b0}};
        end else if (en) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule : regfile_word

// File: rtl/regfile_32x64.sv
// 32 x WIDTH LEGv8 register file: two combinational read ports, one write port, XZR tied to 0.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_32x64 #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    import regfile_pkg::*;

    localparam reg_idx_t ZERO_IDX = reg_idx_t'(ZERO_REG);

    logic [NUM_REGS-1:0] wr_en_s;
    logic [WIDTH-1:0]    regs_s [NUM_REGS];
    logic [WIDTH-1:0]    rd1_s;
    logic [WIDTH-1:0]    rd2_s;

    decoder5_32 u_dec (
        .addr (WriteRegister),
        .en   (RegWrite),
        .y    (wr_en_s)
    );

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
            if (i == ZERO_REG) begin : g_zero
                // The decoder may still select this slot; masking keeps it constant zero
                assign regs_s[i] = {WIDTH{1'b0}} & {WIDTH{wr_en_s[i]}};
            end else begin : g_word
                regfile_word #(.WIDTH(WIDTH)) u_word (
                    .clk   (clk),
                    .reset (reset),
                    .en    (wr_en_s[i]),
                    .d     (WriteData),
                    .q     (regs_s[i])
                );
            end
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    logic fwd1_s;
    logic fwd2_s;

    assign fwd1_s = !reset && RegWrite && (WriteRegister == ReadRegister1) && (WriteRegister != ZERO_IDX);
    assign fwd2_s = !reset && RegWrite && (WriteRegister == ReadRegister2) && (WriteRegister != ZERO_IDX);

    // Read muxes with same-cycle forwarding of the pending write
    always_comb begin
        rd1_s = regs_s[ReadRegister1];
        rd2_s = regs_s[ReadRegister2];
        if (fwd1_s) begin
            rd1_s = WriteData;
        end else begin
            rd1_s = regs_s[ReadRegister1];
        end
        if (fwd2_s) begin
            rd2_s = WriteData;
        end else begin
            rd2_s = regs_s[ReadRegister2];
        end
    end
`else
    // Read muxes; a same-cycle write becomes visible only after the edge
    always_comb begin
        rd1_s = regs_s[ReadRegister1];
        rd2_s = regs_s[ReadRegister2];
    end
`endif

    assign ReadData1 = rd1_s;
    assign ReadData2 = rd2_s;

endmodule : regfile_32x64
